// File: rtl/ifu_iccm_arb.sv
// ICCM port arbiter between instruction fetch and DMA, with in-order DMA read returns.
// Starvation protection (forced fetch stall + bounded DMA hold) is built when RV_ICCM_DMA_STARVE_EN is defined.
module ifu_iccm_arb #(
  parameter int STARVE_MAX = 15,
  parameter int HOLD_MAX   = 8,
  parameter int RD_LAT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ifc_fetch_req_f1,
  input  logic       ifc_iccm_access_f1,
  input  logic       ifc_dma_access_ok,
  input  logic       dma_iccm_req,
  input  logic       dma_iccm_wr,
  input  logic [2:0] dma_iccm_tag,
  output logic       iccm_dma_gnt,
  output logic       iccm_fetch_gnt,
  output logic       dma_iccm_stall_any,
  output logic       iccm_dma_rvalid,
  output logic [2:0] iccm_dma_rtag,
  output logic [2:0] iccm_dma_rd_outstanding
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    FORCE = 2'b10,
    HOLD  = 2'b11
  } arbState_t;

  if (STARVE_MAX < 2 || STARVE_MAX > 255 || HOLD_MAX < 1 || HOLD_MAX > 255 ||
      RD_LAT < 1 || RD_LAT > 4) begin : g_badParams
    $error("ifu_iccm_arb: parameter out of legal range");
  end

  arbState_t   r_state;
  arbState_t   w_nextState;
  logic        w_dmaGnt;
  logic        w_rdGnt;
  logic [RD_LAT-1:0] r_rdVld;
  logic [2:0]  r_rdTag [RD_LAT];
  logic [2:0]  r_rdOut;

`ifdef RV_ICCM_DMA_STARVE_EN
  localparam logic [7:0] STARVE_LAST = 8'(STARVE_MAX - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_MAX - 1);

  logic [7:0]  r_waitCnt;
  logic [7:0]  r_holdCnt;
  logic        r_stall;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (dma_iccm_req && !ifc_dma_access_ok) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (!dma_iccm_req || ifc_dma_access_ok) begin
          w_nextState = IDLE;
        end
`ifdef RV_ICCM_DMA_STARVE_EN
        else if (r_waitCnt == STARVE_LAST) begin
          w_nextState = FORCE;
        end
`endif
      end
`ifdef RV_ICCM_DMA_STARVE_EN
      FORCE: w_nextState = HOLD;
      HOLD: begin
        if (!dma_iccm_req || r_holdCnt == HOLD_LAST) begin
          w_nextState = IDLE;
        end
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

  // Grants are combinational and forced low while reset is held.
  always_comb begin
    w_dmaGnt = 1'b0;
    case (r_state)
      IDLE, WAIT: w_dmaGnt = dma_iccm_req & ifc_dma_access_ok;
`ifdef RV_ICCM_DMA_STARVE_EN
      HOLD:       w_dmaGnt = dma_iccm_req;
`endif
      default:    w_dmaGnt = 1'b0;
    endcase
    iccm_dma_gnt   = w_dmaGnt & ~rst;
    iccm_fetch_gnt = ifc_fetch_req_f1 & ifc_iccm_access_f1 & ~iccm_dma_gnt & ~rst;
  end

`ifdef RV_ICCM_DMA_STARVE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waitCnt <= '0;
      r_holdCnt <= '0;
      r_stall   <= 1'b0;
    end else begin
      if (w_nextState == WAIT) begin
        if (r_state != WAIT) begin
          r_waitCnt <= 8'd1;
        end else if (r_waitCnt != 8'hFF) begin
          r_waitCnt <= r_waitCnt + 8'd1;
        end
      end else begin
        r_waitCnt <= '0;
      end
      // Staying in HOLD always implies a grant was issued this cycle.
      if (r_state == HOLD && w_nextState == HOLD) begin
        if (r_holdCnt != 8'hFF) begin
          r_holdCnt <= r_holdCnt + 8'd1;
        end
      end else begin
        r_holdCnt <= '0;
      end
      r_stall <= (w_nextState == FORCE) || (w_nextState == HOLD);
    end
  end

  assign dma_iccm_stall_any = r_stall;
`else
  assign dma_iccm_stall_any = 1'b0;
`endif

  assign w_rdGnt = iccm_dma_gnt & ~dma_iccm_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdVld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_rdTag[i] <= '0;
      end
    end else begin
      r_rdVld[0] <= w_rdGnt;
      r_rdTag[0] <= w_rdGnt ? dma_iccm_tag : 3'd0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rdVld[i] <= r_rdVld[i-1];
        r_rdTag[i] <= r_rdTag[i-1];
      end
    end
  end

  assign iccm_dma_rvalid = r_rdVld[RD_LAT-1];
  assign iccm_dma_rtag   = r_rdTag[RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdOut <= '0;
    end else begin
      case ({w_rdGnt, iccm_dma_rvalid})
        2'b10:   r_rdOut <= r_rdOut + 3'd1;
        2'b01:   r_rdOut <= r_rdOut - 3'd1;
        default: r_rdOut <= r_rdOut;
      endcase
    end
  end

  assign iccm_dma_rd_outstanding = r_rdOut;

endmodule

// File: tb/tb_ifu_iccm_arb.sv
// Testbench for ifu_iccm_arb: directed vectors checked by a cycle-level behavioural model
// plus hand-computed literal expectations; honours RV_ICCM_DMA_STARVE_EN like the design.
module tb_ifu_iccm_arb;

  localparam int STARVE_MAX = 15;
  localparam int HOLD_MAX   = 8;
  localparam int RD_LAT     = 2;
`ifdef RV_ICCM_DMA_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       fetchReq, iccmAccess, accessOk, dmaReq, dmaWr;
  logic [2:0] dmaTag;
  logic       dmaGnt, fetchGnt, stallAny, rvalid;
  logic [2:0] rtag, rdOut;

  int compared   = 0;
  int mismatched = 0;

  ifu_iccm_arb #(.STARVE_MAX(STARVE_MAX), .HOLD_MAX(HOLD_MAX), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .ifc_fetch_req_f1(fetchReq),
    .ifc_iccm_access_f1(iccmAccess),
    .ifc_dma_access_ok(accessOk),
    .dma_iccm_req(dmaReq),
    .dma_iccm_wr(dmaWr),
    .dma_iccm_tag(dmaTag),
    .iccm_dma_gnt(dmaGnt),
    .iccm_fetch_gnt(fetchGnt),
    .dma_iccm_stall_any(stallAny),
    .iccm_dma_rvalid(rvalid),
    .iccm_dma_rtag(rtag),
    .iccm_dma_rd_outstanding(rdOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic a, input logic ok,
                               input logic req, input logic wr, input logic [2:0] tag);
    @(posedge clk);
    #1;
    fetchReq   = f;
    iccmAccess = a;
    accessOk   = ok;
    dmaReq     = req;
    dmaWr      = wr;
    dmaTag     = tag;
  endtask

  // Model: a DMA request starves after STARVE_MAX consecutive denied cycles; then one
  // blocked cycle, then up to HOLD_MAX unconditional grants. Reads return RD_LAT cycles later.
  int         denied     = 0;
  bit         inForce    = 1'b0;
  bit         inHold     = 1'b0;
  int         holdGrants = 0;
  int         cyc        = 0;
  bit         histVld [8];
  logic [2:0] histTag [8];

  initial begin : modelCheck
    logic expGnt, expFetch, expStall, expRvalid;
    logic [2:0] expRtag;
    int expOut;
    int slot;
    for (int k = 0; k < 8; k++) begin
      histVld[k] = 1'b0;
      histTag[k] = 3'd0;
    end
    forever begin
      @(negedge clk);
      checkOutput("mutex", {31'd0, dmaGnt & fetchGnt}, 32'd0);
      if (rst) begin
        checkOutput("rst_gnt", dmaGnt, 1'b0);
        checkOutput("rst_fetch", fetchGnt, 1'b0);
        checkOutput("rst_stall", stallAny, 1'b0);
        checkOutput("rst_rvalid", rvalid, 1'b0);
        checkOutput("rst_rtag", rtag, 3'd0);
        checkOutput("rst_out", rdOut, 3'd0);
        denied = 0; inForce = 1'b0; inHold = 1'b0; holdGrants = 0; cyc = 0;
        for (int k = 0; k < 8; k++) begin
          histVld[k] = 1'b0;
          histTag[k] = 3'd0;
        end
      end else begin
        expGnt    = inForce ? 1'b0 : (inHold ? dmaReq : (dmaReq & accessOk));
        expFetch  = fetchReq & iccmAccess & ~expGnt;
        expStall  = inForce | inHold;
        slot      = (cyc + 8 - RD_LAT) % 8;
        expRvalid = histVld[slot];
        expRtag   = histVld[slot] ? histTag[slot] : 3'd0;
        expOut    = 0;
        for (int k = 1; k <= RD_LAT; k++) begin
          if (histVld[(cyc + 8 - k) % 8]) expOut++;
        end
        checkOutput("gnt", dmaGnt, expGnt);
        checkOutput("fetch_gnt", fetchGnt, expFetch);
        checkOutput("stall_any", stallAny, expStall);
        checkOutput("rvalid", rvalid, expRvalid);
        checkOutput("rtag", rtag, expRtag);
        checkOutput("outstanding", rdOut, expOut);
        histVld[cyc % 8] = expGnt & ~dmaWr;
        histTag[cyc % 8] = dmaTag;
        if (inForce) begin
          inForce = 1'b0;
          inHold = 1'b1;
          holdGrants = 0;
        end else if (inHold) begin
          if (!dmaReq) begin
            inHold = 1'b0;
          end else begin
            holdGrants++;
            if (holdGrants == HOLD_MAX) inHold = 1'b0;
          end
          denied = 0;
        end else if (dmaReq && !accessOk) begin
          denied++;
          if (STARVE_EN && denied == STARVE_MAX) begin
            inForce = 1'b1;
            denied = 0;
          end
        end else begin
          denied = 0;
        end
        cyc++;
      end
    end
  end

  initial begin : stimulus
    int gntCount, stallCount, rvCount;
    rst = 1'b1;
    fetchReq = 1'b1; iccmAccess = 1'b1; accessOk = 1'b1; dmaReq = 1'b1; dmaWr = 1'b0; dmaTag = 3'd2;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_gnt_blocked", dmaGnt, 1'b0);
    checkOutput("reset_fetch_blocked", fetchGnt, 1'b0);
    checkOutput("reset_out", rdOut, 3'd0);
    applyStimulus(0, 0, 0, 0, 0, 3'd0);
    rst = 1'b0;

    // Single read, tag 5, returns two cycles after the grant.
    applyStimulus(0, 0, 1, 1, 0, 3'd5); #2;
    checkOutput("rd5_gnt", dmaGnt, 1'b1);
    applyStimulus(0, 0, 1, 0, 0, 3'd0); #2;
    checkOutput("rd5_out_c1", rdOut, 3'd1);
    checkOutput("rd5_rvalid_c1", rvalid, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 3'd0); #2;
    checkOutput("rd5_rvalid_c2", rvalid, 1'b1);
    checkOutput("rd5_rtag_c2", rtag, 3'd5);
    checkOutput("rd5_out_c2", rdOut, 3'd1);
    applyStimulus(0, 0, 0, 0, 0, 3'd0); #2;
    checkOutput("rd5_out_c3", rdOut, 3'd0);
    checkOutput("rd5_rvalid_c3", rvalid, 1'b0);

    // Fetch alone, then fetch colliding with a DMA write.
    applyStimulus(1, 1, 0, 0, 0, 3'd0); #2;
    checkOutput("fetch_alone", fetchGnt, 1'b1);
    applyStimulus(1, 1, 1, 1, 1, 3'd3); #2;
    checkOutput("wr_gnt", dmaGnt, 1'b1);
    checkOutput("wr_fetch_blocked", fetchGnt, 1'b0);
    applyStimulus(0, 0, 1, 0, 0, 3'd0);
    applyStimulus(0, 0, 1, 0, 0, 3'd0); #2;
    checkOutput("wr_no_rvalid", rvalid, 1'b0);

    // Back-to-back reads return in order.
    applyStimulus(0, 0, 1, 1, 0, 3'd1);
    applyStimulus(0, 0, 1, 1, 0, 3'd2);
    applyStimulus(0, 0, 1, 1, 0, 3'd3); #2;
    checkOutput("b2b_rtag1", {rvalid, rtag}, {1'b1, 3'd1});
    checkOutput("b2b_out", rdOut, 3'd2);
    applyStimulus(0, 0, 1, 0, 0, 3'd0); #2;
    checkOutput("b2b_rtag2", {rvalid, rtag}, {1'b1, 3'd2});
    applyStimulus(0, 0, 1, 0, 0, 3'd0); #2;
    checkOutput("b2b_rtag3", {rvalid, rtag}, {1'b1, 3'd3});

    // Reset with two reads outstanding discards them.
    applyStimulus(0, 0, 1, 1, 0, 3'd6);
    applyStimulus(0, 0, 1, 1, 0, 3'd7);
    applyStimulus(0, 0, 1, 1, 1, 3'd0); #2;
    checkOutput("pre_rst_out", rdOut, 3'd2);
    rst = 1'b1; #1;
    checkOutput("mid_rst_rvalid", rvalid, 1'b0);
    checkOutput("mid_rst_out", rdOut, 3'd0);
    checkOutput("mid_rst_gnt", dmaGnt, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 3'd0);
    rst = 1'b0;
    rvCount = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 3'd0); #2;
      if (rvalid) rvCount++;
    end
    checkOutput("no_rvalid_after_rst", rvCount, 0);

`ifdef RV_ICCM_DMA_STARVE_EN
    // Starvation: 15 denied cycles, one forced-stall cycle, then 8 hold grants.
    begin
      logic [25:0] gHist, sHist, fHist;
      for (int i = 0; i < 26; i++) begin
        applyStimulus(1, 1, 0, 1, 0, 3'(i)); #2;
        gHist[i] = dmaGnt; sHist[i] = stallAny; fHist[i] = fetchGnt;
      end
      checkOutput("starve_stall_c14", sHist[14], 1'b0);
      checkOutput("starve_stall_c15", sHist[15], 1'b1);
      checkOutput("starve_gnt_0_15", gHist[15:0], 16'd0);
      checkOutput("starve_gnt_16_23", gHist[23:16], 8'hFF);
      checkOutput("starve_fetch_c15", fHist[15], 1'b1);
      checkOutput("starve_fetch_c16", fHist[16], 1'b0);
      checkOutput("hold_exit_stall_c24", sHist[24], 1'b0);
      checkOutput("hold_exit_gnt_24_25", gHist[25:24], 2'b00);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 3'd0);
    end
`endif

    // Access never allowed for 100 cycles with a request pending.
    gntCount = 0; stallCount = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 3'd0); #2;
      if (dmaGnt) gntCount++;
      if (stallAny) stallCount++;
    end
`ifdef RV_ICCM_DMA_STARVE_EN
    checkOutput("long_deny_gnts", gntCount, 32);
    checkOutput("long_deny_stalls", stallCount, 36);
`else
    checkOutput("long_deny_gnts", gntCount, 0);
    checkOutput("long_deny_stalls", stallCount, 0);
`endif
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 3'd0);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
